// File: rtl/key_event_sched.sv
// key_event_sched: latches debounced key presses, arbitrates them round-robin into an event FIFO.
// Define KEY_REPEAT_EN to add per-key hold timers that generate auto-repeat events.
module key_event_sched #(
    parameter int N_KEY      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int REPEAT_DLY = 50_000_000,
    parameter int REPEAT_PER = 10_000_000
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [N_KEY-1:0]         i_level,
    input  logic [N_KEY-1:0]         i_pos,
    input  logic                     i_ready,
    output logic                     o_valid,
    output logic [$clog2(N_KEY)-1:0] o_key,
    output logic                     o_rep,
    output logic                     o_drop
);
    localparam int KW = $clog2(N_KEY);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = KW + 1;

    logic [N_KEY-1:0] r_pend;
    logic [N_KEY-1:0] r_ptag;
    logic [KW-1:0]    r_last;
    logic [EW-1:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW:0]      r_count;
    logic             r_drop;

    logic [N_KEY-1:0] w_evt;
    logic [N_KEY-1:0] w_etag;
    logic [N_KEY-1:0] w_gnt;
    logic [N_KEY-1:0] w_take;
    logic             w_pop;
    logic             w_push_ok;
    logic             w_found;
    logic             w_push;
    logic [KW-1:0]    w_gidx;

`ifdef KEY_REPEAT_EN
    localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int TW   = (RMAX > 2) ? $clog2(RMAX) : 1;

    logic [TW-1:0]    r_tmr [N_KEY];
    logic [N_KEY-1:0] r_rep_on;
    logic [N_KEY-1:0] w_fire;

    // r_rep_on selects the first-repeat delay versus the steady repeat period
    always_comb begin
        for (int k = 0; k < N_KEY; k++) begin
            w_fire[k] = i_level[k] && !i_pos[k] &&
                        (r_rep_on[k] ? (r_tmr[k] == TW'(REPEAT_PER - 1))
                                     : (r_tmr[k] == TW'(REPEAT_DLY - 1)));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < N_KEY; k++) begin
                r_tmr[k] <= '0;
            end
            r_rep_on <= '0;
        end else begin
            for (int k = 0; k < N_KEY; k++) begin
                if (!i_level[k] || i_pos[k]) begin
                    r_tmr[k]    <= '0;
                    r_rep_on[k] <= 1'b0;
                end else if (w_fire[k]) begin
                    r_tmr[k]    <= '0;
                    r_rep_on[k] <= 1'b1;
                end else begin
                    r_tmr[k] <= r_tmr[k] + TW'(1);
                end
            end
        end
    end

    assign w_evt  = i_pos | w_fire;
    assign w_etag = ~i_pos;
`else
    logic w_unused;
    assign w_unused = ^{i_level, REPEAT_DLY > 0, REPEAT_PER > 0};
    assign w_evt    = i_pos;
    assign w_etag   = '0;
`endif

    assign w_pop     = o_valid && i_ready;
    assign w_push_ok = (r_count < (PW+1)'(FIFO_DEPTH)) || w_pop;

    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_gidx  = '0;
        for (int i = 1; i <= N_KEY; i++) begin
            idx = int'(r_last) + i;
            if (idx >= N_KEY) idx = idx - N_KEY;
            if (!w_found && r_pend[KW'(idx)]) begin
                w_found = 1'b1;
                w_gidx  = KW'(idx);
            end
        end
    end

    assign w_push = w_found && w_push_ok;

    always_comb begin
        w_gnt = '0;
        if (w_push) w_gnt[w_gidx] = 1'b1;
    end

    // an event is accepted unless the key is still pending and not leaving this cycle
    assign w_take = w_evt & ~(r_pend & ~w_gnt);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend <= '0;
            r_ptag <= '0;
            r_last <= KW'(N_KEY - 1);
            r_drop <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_gnt) | w_evt;
            r_ptag <= (r_ptag & ~w_take) | (w_etag & w_take);
            r_drop <= |(w_evt & r_pend & ~w_gnt);
            if (w_push) r_last <= w_gidx;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int d = 0; d < FIFO_DEPTH; d++) begin
                r_mem[d] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= {r_ptag[w_gidx], w_gidx};
                r_wptr        <= r_wptr + PW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + PW'(1);
            if (w_push && !w_pop) r_count <= r_count + (PW+1)'(1);
            else if (!w_push && w_pop) r_count <= r_count - (PW+1)'(1);
        end
    end

    assign o_valid        = (r_count != '0);
    assign {o_rep, o_key} = r_mem[r_rptr];
    assign o_drop         = r_drop;

endmodule

// File: tb/tb_key_event_sched.sv
// Bench for key_event_sched: directed vector table, corner sequences, and random
// traffic against a queue-based reference model of the pending/arbiter/FIFO rules.
`timescale 1ns/1ps
module tb_key_event_sched;
    localparam int NK = 4;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NK-1:0] level;
    logic [NK-1:0] pos;
    logic          ready;
    logic          valid;
    logic [1:0]    key;
    logic          rep;
    logic          drop;

    int n_cmp = 0;
    int n_bad = 0;

    key_event_sched #(
        .N_KEY(NK), .FIFO_DEPTH(D), .REPEAT_DLY(20), .REPEAT_PER(8)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_level(level), .i_pos(pos),
        .i_ready(ready), .o_valid(valid), .o_key(key), .o_rep(rep),
        .o_drop(drop)
    );

    always #5 clk = ~clk;

    bit m_pend[NK];
    int m_last;
    int mq[$];
    bit m_drop;
    bit mdl_on = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NK; k++) m_pend[k] = 1'b0;
        m_last = NK - 1;
        mq.delete();
        m_drop = 1'b0;
    endtask

    // Pop first, then grant the next pending key after the last winner, then latch events
    task automatic model_step(input logic [NK-1:0] p, input logic r);
        bit pop;
        bit can;
        bit d;
        int g;
        pop = (mq.size() > 0) && r;
        can = (mq.size() < D) || pop;
        g = -1;
        if (can) begin
            for (int i = 1; i <= NK; i++) begin
                int k = (m_last + i) % NK;
                if (g < 0 && m_pend[k]) g = k;
            end
        end
        if (pop) mq.delete(0);
        if (g >= 0) begin
            mq.push_back(g);
            m_pend[g] = 1'b0;
            m_last = g;
        end
        d = 1'b0;
        for (int k = 0; k < NK; k++) begin
            if (p[k]) begin
                if (m_pend[k]) d = 1'b1;
                m_pend[k] = 1'b1;
            end
        end
        m_drop = d;
    endtask

    task automatic model_chk();
        if (mdl_on) begin
            chk("m_valid", valid, mq.size() > 0);
            if (mq.size() > 0) begin
                chk("m_key", key, mq[0]);
                chk("m_rep", rep, 0);
            end
            chk("m_drop", drop, m_drop);
        end
    endtask

    task automatic cycle(input logic [NK-1:0] p, input logic r);
        pos   = p;
        ready = r;
        @(posedge clk);
        model_step(p, r);
        #1;
        model_chk();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pos   = '0;
        ready = 1'b0;
        level = '0;
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_key", key, 0);
        chk("rst_rep", rep, 0);
        chk("rst_drop", drop, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct packed {
        logic [NK-1:0] p;
        logic          r;
        logic          ev;
        logic [1:0]    ek;
        logic          ed;
    } vec_t;

    vec_t tbl[13];
    int   n;
    int   got[$];
    int   rtime[$];
    int   rtag[$];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{4'b1111, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[1]  = '{4'b0000, 1'b0, 1'b1, 2'd0, 1'b0};
        tbl[2]  = '{4'b0000, 1'b0, 1'b1, 2'd0, 1'b0};
        tbl[3]  = '{4'b0000, 1'b0, 1'b1, 2'd0, 1'b0};
        tbl[4]  = '{4'b0000, 1'b0, 1'b1, 2'd0, 1'b0};
        tbl[5]  = '{4'b0000, 1'b1, 1'b1, 2'd1, 1'b0};
        tbl[6]  = '{4'b0000, 1'b1, 1'b1, 2'd2, 1'b0};
        tbl[7]  = '{4'b0000, 1'b1, 1'b1, 2'd3, 1'b0};
        tbl[8]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b0};
        tbl[9]  = '{4'b0100, 1'b1, 1'b0, 2'd0, 1'b0};
        tbl[10] = '{4'b0000, 1'b1, 1'b1, 2'd2, 1'b0};
        tbl[11] = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b0};
        tbl[12] = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b0};

        do_reset();

        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].p, tbl[i].r);
            chk($sformatf("tbl%0d_valid", i), valid, tbl[i].ev);
            if (tbl[i].ev) chk($sformatf("tbl%0d_key", i), key, tbl[i].ek);
            chk($sformatf("tbl%0d_drop", i), drop, tbl[i].ed);
        end

        // Coalesce under backpressure: full FIFO, key 0 pressed twice
        cycle(4'b1111, 1'b0);
        for (int i = 0; i < 4; i++) cycle('0, 1'b0);
        cycle(4'b0001, 1'b0);
        chk("coal_drop0", drop, 0);
        cycle(4'b0001, 1'b0);
        chk("coal_drop1", drop, 1);
        cycle('0, 1'b0);
        chk("coal_drop2", drop, 0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (valid) n++;
            cycle('0, 1'b1);
        end
        chk("coal_drain_cnt", n, 5);
        chk("coal_empty", valid, 0);

        // Round-robin fairness between keys 1 and 3
        do_reset();
        got.delete();
        for (int i = 0; i < 12; i++) begin
            if (valid) got.push_back(int'(key));
            cycle(4'b1010, 1'b1);
        end
        for (int i = 0; i < 4; i++) cycle('0, 1'b1);
        if (got.size() < 6) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rr_count: got %0d pops, want >= 6", got.size());
        end else begin
            for (int i = 0; i < 6; i++) chk($sformatf("rr_key%0d", i), got[i], (i % 2 == 0) ? 1 : 3);
        end

        // Reset mid-operation discards queued and pending events
        cycle(4'b0111, 1'b0);
        cycle(4'b1000, 1'b0);
        cycle('0, 1'b0);
        cycle('0, 1'b0);
        chk("pre_rst_valid", valid, 1);
        do_reset();
        for (int i = 0; i < 5; i++) cycle('0, 1'b1);
        chk("post_rst_idle", valid, 0);
        cycle(4'b0001, 1'b1);
        cycle('0, 1'b1);
        chk("post_rst_valid", valid, 1);
        chk("post_rst_key", key, 0);
        cycle('0, 1'b1);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [NK-1:0] p;
            logic r;
            p = NK'($urandom & $urandom & $urandom);
            r = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            cycle(p, r);
        end
        for (int i = 0; i < 12; i++) cycle('0, 1'b1);
        chk("rand_empty", valid, 0);

`ifdef KEY_REPEAT_EN
        // Hold key 1 for 40 cycles: press at 1, repeats at 21, 29, 37
        do_reset();
        mdl_on = 1'b0;
        rtime.delete();
        rtag.delete();
        level = 4'b0010;
        for (int c = 0; c < 50; c++) begin
            if (c == 40) level = '0;
            pos   = (c == 0) ? 4'b0010 : 4'b0000;
            ready = 1'b1;
            @(posedge clk);
            #1;
            if (valid) begin
                rtime.push_back(c);
                rtag.push_back(int'(rep));
            end
        end
        chk("rep_cnt", rtime.size(), 4);
        if (rtime.size() == 4) begin
            chk("rep_t0", rtime[0], 1);
            chk("rep_r0", rtag[0], 0);
            chk("rep_t1", rtime[1], 21);
            chk("rep_r1", rtag[1], 1);
            chk("rep_t2", rtime[2], 29);
            chk("rep_r2", rtag[2], 1);
            chk("rep_t3", rtime[3], 37);
            chk("rep_r3", rtag[3], 1);
        end
        mdl_on = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
